// File: rtl/pair_var_pkg.sv
// pair_var_pkg: shared widths and pipeline latency for the variance unit.
// Define PAIR_VAR_OUT_REG_EN to add one output register stage (latency 5).
package pair_var_pkg;

    localparam int N_LANES = 64;
    localparam int DATA_W  = 16;
    localparam int OUT_W   = 32;
    localparam int LOG2_N  = 6;

    localparam int PSUM_W  = DATA_W + 1;
    localparam int SQ_W    = 2 * DATA_W;
    localparam int SUMX_W  = DATA_W + LOG2_N;
    localparam int SUMSQ_W = 2 * DATA_W - 1 + LOG2_N;
    localparam int MSQ_W   = 2 * SUMX_W;
    localparam int N_MID   = 8;

`ifdef PAIR_VAR_OUT_REG_EN
    localparam int LATENCY = 5;
`else
    localparam int LATENCY = 4;
`endif

endpackage

// File: rtl/pair_var_tree.sv
// pair_var_tree: registered two-level adder tree, N_IN -> N_MID -> 1.
// Inputs are sign- or zero-extended to OUT_W before any addition.
module pair_var_tree #(
    parameter int IN_W      = 17,
    parameter int N_IN      = 32,
    parameter int OUT_W     = 22,
    parameter int N_MID     = 8,
    parameter bit IS_SIGNED = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [N_IN*IN_W-1:0] data_i,
    output logic [OUT_W-1:0]     sum_o
);

    localparam int G = N_IN / N_MID;

    logic [OUT_W-1:0] mid_d [N_MID];
    logic [OUT_W-1:0] mid_q [N_MID];
    logic [OUT_W-1:0] sum_d;
    logic [OUT_W-1:0] sum_q;

    function automatic logic [OUT_W-1:0] widen(
        input logic [IN_W-1:0] v
    );
        logic ext;
        ext = IS_SIGNED & v[IN_W-1];
        return {{(OUT_W-IN_W){ext}}, v};
    endfunction

    always_comb begin
        for (int m = 0; m < N_MID; m++) begin
            mid_d[m] = '0;
            for (int g = 0; g < G; g++) begin
                mid_d[m] = mid_d[m]
                         + widen(data_i[(m*G+g)*IN_W +: IN_W]);
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int m = 0; m < N_MID; m++) begin
            sum_d = sum_d + mid_q[m];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int m = 0; m < N_MID; m++) begin
                mid_q[m] <= '0;
            end
            sum_q <= '0;
        end else if (en_i) begin
            for (int m = 0; m < N_MID; m++) begin
                mid_q[m] <= mid_d[m];
            end
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/pair_var.sv
// pair_var: streaming population variance, E[X^2] - E[X]^2, one beat/cycle.
// Define PAIR_VAR_OUT_REG_EN for an extra output register (latency 5).
module pair_var
    import pair_var_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  logic [N_LANES*DATA_W-1:0] i_data_flat,
    output logic                      o_valid,
    output logic [OUT_W-1:0]          o_variance
);

    localparam int N_PAIR = N_LANES / 2;

    logic signed [SQ_W-1:0]   xw [N_LANES];
    logic [N_LANES*SQ_W-1:0]  sq_d;
    logic [N_LANES*SQ_W-1:0]  sq_q;
    logic [N_PAIR*PSUM_W-1:0] ps_d;
    logic [N_PAIR*PSUM_W-1:0] ps_q;

    logic [SUMX_W-1:0]  sumx;
    logic [SUMSQ_W-1:0] sumsq;

    logic signed [MSQ_W-1:0] sxw;
    logic [MSQ_W-1:0]        prod;
    logic [MSQ_W-1:0]        msq;
    logic [SUMSQ_W-1:0]      sqm;
    logic [OUT_W-1:0]        var_d;
    logic [OUT_W-1:0]        var_q;

    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] vld_q;

    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            xw[k] = $signed({
                {(SQ_W-DATA_W){i_data_flat[k*DATA_W+DATA_W-1]}},
                i_data_flat[k*DATA_W +: DATA_W]});
        end
    end

    // S1: squares and pairwise sums, all kept at full precision
    always_comb begin
        sq_d = '0;
        ps_d = '0;
        for (int k = 0; k < N_LANES; k++) begin
            sq_d[k*SQ_W +: SQ_W] = xw[k] * xw[k];
        end
        for (int j = 0; j < N_PAIR; j++) begin
            ps_d[j*PSUM_W +: PSUM_W] = PSUM_W'(xw[2*j])
                                     + PSUM_W'(xw[2*j+1]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sq_q <= '0;
            ps_q <= '0;
        end else if (i_en) begin
            sq_q <= sq_d;
            ps_q <= ps_d;
        end
    end

    // S2/S3 live inside the trees
    pair_var_tree #(
        .IN_W      (PSUM_W),
        .N_IN      (N_PAIR),
        .OUT_W     (SUMX_W),
        .N_MID     (N_MID),
        .IS_SIGNED (1'b1)
    ) u_sumx (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .en_i   (i_en),
        .data_i (ps_q),
        .sum_o  (sumx)
    );

    pair_var_tree #(
        .IN_W      (SQ_W),
        .N_IN      (N_LANES),
        .OUT_W     (SUMSQ_W),
        .N_MID     (N_MID),
        .IS_SIGNED (1'b0)
    ) u_sumsq (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .en_i   (i_en),
        .data_i (sq_q),
        .sum_o  (sumsq)
    );

    // S4: both terms are within [0, 2^30], so the difference fits OUT_W
    always_comb begin
        sxw   = $signed({{(MSQ_W-SUMX_W){sumx[SUMX_W-1]}}, sumx});
        prod  = sxw * sxw;
        msq   = prod >> (2 * LOG2_N);
        sqm   = sumsq >> LOG2_N;
        var_d = OUT_W'(sqm) - OUT_W'(msq);
    end

    assign vld_d = {vld_q[LATENCY-2:0], i_valid};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
            var_q <= '0;
        end else if (i_en) begin
            vld_q <= vld_d;
            var_q <= var_d;
        end
    end

`ifdef PAIR_VAR_OUT_REG_EN
    logic [OUT_W-1:0] out_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q <= '0;
        end else if (i_en) begin
            out_q <= var_q;
        end
    end

    assign o_variance = out_q;
`else
    assign o_variance = var_q;
`endif

    assign o_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_pair_var.sv
// tb_pair_var: directed and streaming checks for pair_var.
// Expected values come from hand constants and a cycle model of the pipe.
module tb_pair_var;
    import pair_var_pkg::*;

    localparam int DW = N_LANES * DATA_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b1;
    logic             vin = 1'b0;
    logic [DW-1:0]    din = '0;
    logic             vout;
    logic [OUT_W-1:0] vo;

    int checks = 0;
    int errors = 0;

    logic             mv [LATENCY];
    logic [OUT_W-1:0] mr [LATENCY];

    always #5 clk = ~clk;

    pair_var dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_valid     (vin),
        .i_data_flat (din),
        .o_valid     (vout),
        .o_variance  (vo)
    );

    function automatic logic [OUT_W-1:0] ref_var(input logic [DW-1:0] d);
        longint sx, ss, x, r;
        logic [15:0] w;
        sx = 0;
        ss = 0;
        for (int k = 0; k < N_LANES; k++) begin
            w = d[k*16 +: 16];
            x = longint'($signed(w));
            sx += x;
            ss += x * x;
        end
        r = (ss >>> 6) - ((sx * sx) >>> 12);
        return r[31:0];
    endfunction

    function automatic logic [DW-1:0] fill_alt(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [DW-1:0] d;
        for (int k = 0; k < N_LANES; k++) begin
            d[k*16 +: 16] = (k % 2 == 0) ? a : b;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) begin
            d[w*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LATENCY; i++) begin
            mv[i] = 1'b0;
            mr[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (en) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                mr[i] = mr[i-1];
            end
            mv[0] = vin;
            mr[0] = ref_var(din);
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (vout !== 1'b0 || vo !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b var=%0d want 0/0",
                     vout, vo);
        end
        clear_model();
        tick();
        tick();
        checks++;
        if (vout !== 1'b0 || vo !== '0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b var=%0d want 0/0",
                     vout, vo);
        end
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (vout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle t=%0d: valid=%b want 0",
                         t, vout);
            end
        end
    endtask

    task automatic test_patterns();
        logic [DW-1:0]    pv [7];
        logic [OUT_W-1:0] pe [7];
        pv[0] = fill_alt(16'd0, 16'd0);
        pe[0] = 32'd0;
        pv[1] = fill_alt(16'd100, 16'd100);
        pe[1] = 32'd0;
        pv[2] = fill_alt(-16'sd50, -16'sd50);
        pe[2] = 32'd0;
        pv[3] = fill_alt(16'd10, -16'sd10);
        pe[3] = 32'd100;
        pv[4] = fill_alt(16'h7fff, 16'h8000);
        pe[4] = 32'd1073709056;
        pv[5] = fill_alt(16'h8000, 16'h8000);
        pe[5] = 32'd0;
        pv[6] = '0;
        pv[6][15:0] = 16'h7fff;
        pe[6] = 32'd16514064;
        for (int i = 0; i < 7; i++) begin
            vin = 1'b1;
            din = pv[i];
            for (int t = 1; t <= LATENCY; t++) begin
                tick();
                vin = 1'b0;
                checks++;
                if (vout !== (t == LATENCY)) begin
                    errors++;
                    $display("FAIL pat%0d_lat t=%0d: valid=%b", i, t, vout);
                end
            end
            checks++;
            if (vo !== pe[i]) begin
                errors++;
                $display("FAIL pat%0d_val: got %0d want %0d",
                         i, vo, pe[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 100 + LATENCY + 2; c++) begin
            vin = (c < 100);
            din = rand_vec();
            tick();
            checks++;
            if (vout !== mv[LATENCY-1]) begin
                errors++;
                $display("FAIL b2b_valid c=%0d: got %b want %b",
                         c, vout, mv[LATENCY-1]);
            end
            if (mv[LATENCY-1]) begin
                checks++;
                if (vo !== mr[LATENCY-1]) begin
                    errors++;
                    $display("FAIL b2b_val c=%0d: got %0d want %0d",
                             c, vo, mr[LATENCY-1]);
                end
            end
            if (vout === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        vin = 1'b0;
        checks++;
        if (cnt != 100 || last - first + 1 != 100) begin
            errors++;
            $display("FAIL b2b_count: got %0d span %0d want 100",
                     cnt, last - first + 1);
        end
    endtask

    task automatic test_enable();
        int cnt = 0;
        logic pvld;
        logic [OUT_W-1:0] pval;
        logic pen;
        for (int c = 0; c < 23 + LATENCY + 2; c++) begin
            en = !(c >= 8 && c < 11);
            vin = (c < 23);
            din = rand_vec();
            pvld = vout;
            pval = vo;
            pen = en;
            tick();
            checks++;
            if (vout !== mv[LATENCY-1]) begin
                errors++;
                $display("FAIL en_valid c=%0d: got %b want %b",
                         c, vout, mv[LATENCY-1]);
            end
            if (mv[LATENCY-1]) begin
                checks++;
                if (vo !== mr[LATENCY-1]) begin
                    errors++;
                    $display("FAIL en_val c=%0d: got %0d want %0d",
                             c, vo, mr[LATENCY-1]);
                end
            end
            if (!pen) begin
                checks++;
                if (vout !== pvld || vo !== pval) begin
                    errors++;
                    $display("FAIL en_stall c=%0d: %b/%0d want %b/%0d",
                             c, vout, vo, pvld, pval);
                end
            end
            if (pen && vout === 1'b1) cnt++;
        end
        en = 1'b1;
        vin = 1'b0;
        checks++;
        if (cnt != 20) begin
            errors++;
            $display("FAIL en_count: got %0d want 20", cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 6; c++) begin
            vin = 1'b1;
            din = rand_vec();
            tick();
        end
        #2 rst = 1'b1;
        vin = 1'b0;
        #1;
        checks++;
        if (vout !== 1'b0 || vo !== '0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b var=%0d want 0/0",
                     vout, vo);
        end
        clear_model();
        tick();
        rst = 1'b0;
        for (int t = 0; t < LATENCY + 2; t++) begin
            tick();
            checks++;
            if (vout !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale t=%0d: valid=%b want 0",
                         t, vout);
            end
        end
        vin = 1'b1;
        din = fill_alt(16'd10, -16'sd10);
        for (int t = 1; t <= LATENCY; t++) begin
            tick();
            vin = 1'b0;
            checks++;
            if (vout !== (t == LATENCY)) begin
                errors++;
                $display("FAIL rstmid_lat t=%0d: valid=%b", t, vout);
            end
        end
        checks++;
        if (vo !== 32'd100) begin
            errors++;
            $display("FAIL rstmid_val: got %0d want 100", vo);
        end
        tick();
    endtask

    initial begin
        clear_model();
        test_reset();
        test_patterns();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
